disp_scan_ctrl: RTL and testbench

// - Scan controller for the 8-digit seven-segment display. It sits directly

---
 rtl/disp_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl
// Scan controller for an 8-digit seven-segment display. It holds a
// double-buffered hex word with per-digit blank and decimal-point masks, and
// steps the active digit once every SCAN_DIV clocks. New data sits in a stage
// register and moves into the displayed (shadow) copy only at a frame wrap,
// or at once while scanning is disabled. A frame therefore never mixes old
// and new data.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   en         scan enable
//   data_in    8 hex nibbles; digit k = data_in[4k+3:4k]
//   blank_in   per-digit blank mask, 1 = dark
//   dp_in      per-digit decimal point, 1 = lit
//   load       one-cycle request to take data_in/blank_in/dp_in
//   load_ack   one-cycle pulse in the cycle the shadow copy commits
//   sel        current digit index (display mux select)
//   an         anodes, active-low
//   nibble     hex nibble of the current digit
//   dp         decimal point of the current digit, active-low
//   frame_done one-cycle pulse as sel wraps from 7 to 0
module disp_scan_ctrl #(
  parameter int SCAN_DIV = 100000,
  parameter int CNT_W    = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] data_in,
  input  logic [7:0]  blank_in,
  input  logic [7:0]  dp_in,
  input  logic        load,
  output logic        load_ack,
  output logic [2:0]  sel,
  output logic [7:0]  an,
  output logic [3:0]  nibble,
  output logic        dp,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic             pend_q, pend_d;
  logic [31:0]      stg_data_q, stg_data_d;
  logic [7:0]       stg_blank_q, stg_blank_d;
  logic [7:0]       stg_dp_q, stg_dp_d;
  logic [31:0]      sh_data_q, sh_data_d;
  logic [7:0]       sh_blank_q, sh_blank_d;
  logic [7:0]       sh_dp_q, sh_dp_d;
  logic             load_ack_q, load_ack_d;
  logic             frame_done_q, frame_done_d;

  logic tick;
  logic wrap;
  logic commit;

  always_comb begin
    tick   = en && (cnt_q == CNT_LAST);
    wrap   = tick && (sel_q == 3'd7);
    commit = pend_q && (wrap || !en);

    cnt_d        = '0;
    sel_d        = sel_q;
    pend_d       = pend_q;
    stg_data_d   = stg_data_q;
    stg_blank_d  = stg_blank_q;
    stg_dp_d     = stg_dp_q;
    sh_data_d    = sh_data_q;
    sh_blank_d   = sh_blank_q;
    sh_dp_d      = sh_dp_q;
    load_ack_d   = commit;
    frame_done_d = wrap;

    if (en && !tick)
      cnt_d = cnt_q + CNT_W'(1);

    if (tick)
      sel_d = sel_q + 3'd1;

    if (load) begin
      stg_data_d  = data_in;
      stg_blank_d = blank_in;
      stg_dp_d    = dp_in;
      pend_d      = 1'b1;
    end

    // A load landing in the commit cycle bypasses the stage register so
    // the freshest data is what becomes visible; pending still clears.
    if (commit) begin
      sh_data_d  = load ? data_in  : stg_data_q;
      sh_blank_d = load ? blank_in : stg_blank_q;
      sh_dp_d    = load ? dp_in    : stg_dp_q;
      pend_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      sel_q        <= 3'd0;
      pend_q       <= 1'b0;
      stg_data_q   <= 32'd0;
      stg_blank_q  <= 8'hFF;
      stg_dp_q     <= 8'd0;
      sh_data_q    <= 32'd0;
      sh_blank_q   <= 8'hFF;
      sh_dp_q      <= 8'd0;
      load_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      pend_q       <= pend_d;
      stg_data_q   <= stg_data_d;
      stg_blank_q  <= stg_blank_d;
      stg_dp_q     <= stg_dp_d;
      sh_data_q    <= sh_data_d;
      sh_blank_q   <= sh_blank_d;
      sh_dp_q      <= sh_dp_d;
      load_ack_q   <= load_ack_d;
      frame_done_q <= frame_done_d;
    end
  end

  logic lit;

  always_comb begin
    lit    = en && !sh_blank_q[sel_q];
    an     = lit ? ~(8'b1 << sel_q) : 8'hFF;
    nibble = sh_data_q[{sel_q, 2'b00} +: 4];
    dp     = ~(sh_dp_q[sel_q] && lit);
  end

  assign sel        = sel_q;
  assign load_ack   = load_ack_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomized and directed bench for disp_scan_ctrl (SCAN_DIV = 4), compared
// cycle by cycle against a behavioural model of the display.
module tb_disp_scan_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] data_in;
  logic [7:0]  blank_in;
  logic [7:0]  dp_in;
  logic        load;
  logic        load_ack;
  logic [2:0]  sel;
  logic [7:0]  an;
  logic [3:0]  nibble;
  logic        dp;
  logic        frame_done;

  disp_scan_ctrl #(.SCAN_DIV(DIV), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .blank_in(blank_in),
    .dp_in(dp_in), .load(load), .load_ack(load_ack), .sel(sel), .an(an),
    .nibble(nibble), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: what the display is showing, held as digit arrays.
  int         m_slot;       // clocks spent in the current digit slot
  int         m_digit;      // digit being shown
  bit         m_waiting;    // new data waiting for the frame boundary
  int         m_nxt_val[8];
  bit         m_nxt_blk[8];
  bit         m_nxt_dp[8];
  int         m_val[8];
  bit         m_blk[8];
  bit         m_dpt[8];
  bit         m_ack;
  bit         m_fd;

  task automatic model_reset();
    m_slot = 0; m_digit = 0; m_waiting = 0; m_ack = 0; m_fd = 0;
    for (int k = 0; k < 8; k++) begin
      m_nxt_val[k] = 0; m_nxt_blk[k] = 1; m_nxt_dp[k] = 0;
      m_val[k] = 0; m_blk[k] = 1; m_dpt[k] = 0;
    end
  endtask

  // Advance one clock using the inputs that were present at that edge.
  task automatic model_step();
    bit end_slot, end_frame, take;
    end_slot  = en && (m_slot == DIV - 1);
    end_frame = end_slot && (m_digit == 7);
    take      = m_waiting && (end_frame || !en);
    m_ack = take;
    m_fd  = end_frame;
    for (int k = 0; k < 8; k++) begin
      if (take) begin
        m_val[k] = load ? int'((data_in >> (4 * k)) & 32'hF) : m_nxt_val[k];
        m_blk[k] = load ? blank_in[k] : m_nxt_blk[k];
        m_dpt[k] = load ? dp_in[k] : m_nxt_dp[k];
      end
      if (load) begin
        m_nxt_val[k] = int'((data_in >> (4 * k)) & 32'hF);
        m_nxt_blk[k] = blank_in[k];
        m_nxt_dp[k]  = dp_in[k];
      end
    end
    if (take) m_waiting = 0;
    else if (load) m_waiting = 1;
    m_slot = en ? (m_slot + 1) % DIV : 0;
    if (end_slot) m_digit = (m_digit + 1) % 8;
  endtask

  task automatic check_all();
    logic [7:0] e_an;
    bit shown;
    shown = en && !m_blk[m_digit];
    e_an  = shown ? (8'hFF ^ (8'h01 << m_digit)) : 8'hFF;
    chk("sel", 32'(sel), 32'(m_digit));
    chk("an", 32'(an), 32'(e_an));
    chk("nibble", 32'(nibble), 32'(m_val[m_digit]));
    chk("dp", 32'(dp), 32'(!(shown && m_dpt[m_digit])));
    chk("load_ack", 32'(load_ack), 32'(m_ack));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
  endtask

  int acks_seen;

  // One clock: model absorbs the edge, then new inputs are applied away from
  // the edge and all outputs are compared.
  task automatic cyc(input bit e, input bit l, input logic [31:0] d,
                     input logic [7:0] b, input logic [7:0] p);
    @(posedge clk);
    model_step();
    #1;
    en = e; load = l; data_in = d; blank_in = b; dp_in = p;
    #1;
    if (load_ack) acks_seen++;
    check_all();
  endtask

  task automatic idle(input bit e, input int n);
    for (int i = 0; i < n; i++) cyc(e, 1'b0, 32'h0, 8'h0, 8'h0);
  endtask

  // Run until the model sits at the given digit/slot; an expired bound fails.
  task automatic run_to(input int digit, input int slot);
    int guard;
    guard = 0;
    while (!(m_digit == digit && m_slot == slot) && guard < 100) begin
      cyc(1'b1, 1'b0, 32'h0, 8'h0, 8'h0);
      guard++;
    end
    if (guard >= 100) chk("run_to_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0;
    data_in = '0; blank_in = '0; dp_in = '0;
    acks_seen = 0;
    model_reset();
    #12;
    check_all();
    rst = 1'b0;

    // Idle after reset.
    idle(1'b0, 20);
    // Scanning with nothing loaded: all dark, sel steps, frame_done pulses.
    idle(1'b1, 70);

    // Immediate commit while disabled.
    cyc(1'b0, 1'b0, 32'h0, 8'h0, 8'h0);
    cyc(1'b0, 1'b1, 32'h76543210, 8'h00, 8'h01);
    cyc(1'b0, 1'b0, 32'h0, 8'h0, 8'h0);
    chk("ack_early", 32'(load_ack), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 8'h0, 8'h0);
    chk("ack_two_later", 32'(load_ack), 32'd1);
    idle(1'b1, 40);

    // Mid-frame load waits for the wrap.
    run_to(3, 0);
    cyc(1'b1, 1'b1, 32'hFFFFFFFF, 8'h00, 8'h00);
    idle(1'b1, 40);

    // Two loads in one frame; only the second shows.
    run_to(1, 1);
    cyc(1'b1, 1'b1, 32'hAAAAAAAA, 8'h00, 8'hF0);
    idle(1'b1, 6);
    cyc(1'b1, 1'b1, 32'h89ABCDEF, 8'h24, 8'h0F);
    acks_seen = 0;
    idle(1'b1, 40);
    chk("one_ack_per_commit", 32'(acks_seen), 32'd1);

    // Load in the commit cycle while a load is pending: bypass.
    run_to(4, 0);
    cyc(1'b1, 1'b1, 32'h11111111, 8'h00, 8'h00);
    run_to(7, 2);
    acks_seen = 0;
    cyc(1'b1, 1'b1, 32'h0F1E2D3C, 8'h80, 8'h55);
    idle(1'b1, 40);
    chk("bypass_one_ack", 32'(acks_seen), 32'd1);

    // Reset with a load pending at sel=5.
    run_to(5, 0);
    cyc(1'b1, 1'b1, 32'hDEADBEEF, 8'h00, 8'hFF);
    cyc(1'b1, 1'b0, 32'h0, 8'h0, 8'h0);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #3;
    check_all();
    rst = 1'b0;
    acks_seen = 0;
    idle(1'b1, 40);
    idle(1'b0, 5);
    chk("no_ack_after_reset", 32'(acks_seen), 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit e, l;
      e = ($urandom_range(0, 19) != 0);
      l = ($urandom_range(0, 24) == 0);
      cyc(e, l, $urandom, 8'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
